// File: rtl/sha_const.sv
// sha_const: shared state type, marker byte and word-geometry helpers for the SHA formatter
package sha_const;
  typedef enum logic [1:0] {FILL, PAD, LEN, EMIT} state_t;
  localparam logic [7:0] MARKER = 8'h80;
  localparam logic [3:0] LEN_WORD = 4'd14;
  function automatic int nt_of(input int nw);
    return nw / 8;
  endfunction
  function automatic int lw_of(input int nw);
    return 2 * nw;
  endfunction
endpackage

// File: rtl/sha_pad_word.sv
// sha_pad_word: masks a final partial word, inserts the 0x80 marker, flags a marker still owed
module sha_pad_word
  import sha_const::*;
#(
  parameter int NW = 32,
  localparam int NT = nt_of(NW),
  localparam int KW = $clog2(NT) + 1
) (
  input  logic [NW-1:0] in_data,
  input  logic [KW-1:0] k,
  input  logic          last,
  output logic [NW-1:0] word,
  output logic          pend
);
  always_comb begin
    word = in_data;
    for (int j = 0; j < NT; j++)
      if (last && j >= int'(k)) word[NW-1-8*j -: 8] = j == int'(k) ? MARKER : 8'h00;
  end
  assign pend = last && int'(k) >= NT;
endmodule

// File: rtl/sha_pad_stream.sv
// sha_pad_stream: streams a message into FIPS 180-4 padded 16-word blocks with index/first/last
module sha_pad_stream
  import sha_const::*;
#(
  parameter int NW = 32,
  parameter int NI = 16,
  localparam int NT = nt_of(NW),
  localparam int LW = lw_of(NW),
  localparam int KW = $clog2(NT) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NW-1:0]    in_data,
  input  logic             in_last,
  input  logic [KW-1:0]    in_bytes,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [16*NW-1:0] out_data,
  output logic [NI-1:0]    out_index,
  output logic             out_first,
  output logic             out_last
);
  localparam logic [NW-1:0] MARKER_WORD = {MARKER, {(NW-8){1'b0}}};
  state_t state, state_d;
  logic [NW-1:0] buf_q [16];
  logic [NW-1:0] buf_d [16];
  logic [3:0] wi, wi_d;
  logic [LW-1:0] bitlen, bitlen_d;
  logic [NI-1:0] blk, blk_d;
  logic pend, pend_d, fin, fin_d, done, done_d;
  logic [KW-1:0] k;
  logic [NW-1:0] word;
  logic wpend;
  assign k = (!in_last || in_bytes > KW'(NT)) ? KW'(NT) : in_bytes;
  sha_pad_word #(.NW(NW)) u_word (
    .in_data(in_data),
    .k(k),
    .last(in_last),
    .word(word),
    .pend(wpend)
  );
  // done marks that the last word is in; a non-final EMIT then resumes padding instead of filling
  always_comb begin
    state_d = state;
    wi_d = wi;
    bitlen_d = bitlen;
    blk_d = blk;
    pend_d = pend;
    fin_d = fin;
    done_d = done;
    buf_d = buf_q;
    case (state)
      FILL: if (in_valid) begin
        buf_d[wi] = word;
        bitlen_d = bitlen + LW'({k, 3'b000});
        wi_d = wi + 4'd1;
        pend_d = wpend;
        done_d = in_last;
        state_d = wi == 4'd15 ? EMIT : !in_last ? FILL :
                  (!wpend && wi == LEN_WORD - 4'd1) ? LEN : PAD;
      end
      PAD: begin
        buf_d[wi] = pend ? MARKER_WORD : '0;
        pend_d = 1'b0;
        wi_d = wi + 4'd1;
        state_d = wi == LEN_WORD - 4'd1 ? LEN : wi == 4'd15 ? EMIT : PAD;
      end
      LEN: begin
        buf_d[LEN_WORD] = bitlen[LW-1:NW];
        buf_d[LEN_WORD + 4'd1] = bitlen[NW-1:0];
        fin_d = 1'b1;
        state_d = EMIT;
      end
      EMIT: if (out_ready) begin
        wi_d = '0;
        blk_d = fin ? '0 : blk + 1'b1;
        bitlen_d = fin ? '0 : bitlen;
        pend_d = fin ? 1'b0 : pend;
        done_d = fin ? 1'b0 : done;
        fin_d = 1'b0;
        state_d = (!fin && done) ? PAD : FILL;
      end
      default: state_d = FILL;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= FILL;
      wi <= '0;
      bitlen <= '0;
      blk <= '0;
      pend <= 1'b0;
      fin <= 1'b0;
      done <= 1'b0;
      for (int i = 0; i < 16; i++) buf_q[i] <= '0;
    end else begin
      state <= state_d;
      wi <= wi_d;
      bitlen <= bitlen_d;
      blk <= blk_d;
      pend <= pend_d;
      fin <= fin_d;
      done <= done_d;
      buf_q <= buf_d;
    end
  for (genvar i = 0; i < 16; i++) assign out_data[i*NW +: NW] = buf_q[i];
  assign in_ready = state == FILL;
  assign out_valid = state == EMIT;
  assign out_index = blk;
  assign out_first = blk == '0;
  assign out_last = fin;
endmodule

// File: tb/tb_sha_pad_stream.sv
// tb_sha_pad_stream: directed messages with a block scoreboard for SHA-256 and SHA-512 geometries
module tb_sha_pad_stream;
  typedef struct {logic [511:0] d; logic [15:0] idx; logic fst; logic lst;} e32_t;
  typedef struct {logic [1023:0] d; logic [15:0] idx; logic fst; logic lst;} e64_t;
  logic clk = 0, rst = 0, ordy = 1;
  logic iv = 0, ir, il = 0, ov, ofst, olst;
  logic [31:0] id = '0;
  logic [2:0] ib = '0;
  logic [511:0] od;
  logic [15:0] oi;
  logic iv6 = 0, ir6, il6 = 0, ov6, of6, ol6;
  logic [63:0] id6 = '0;
  logic [3:0] ib6 = '0;
  logic [1023:0] od6;
  logic [15:0] oi6;
  int checks = 0, errors = 0;
  e32_t q32[$];
  e64_t q64[$];
  e32_t m32;
  e64_t m64;
  logic bad32, bad64;
  always #5 clk = ~clk;
  sha_pad_stream #(.NW(32), .NI(16)) d32 (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .in_data(id), .in_last(il),
    .in_bytes(ib), .out_valid(ov), .out_ready(ordy), .out_data(od), .out_index(oi),
    .out_first(ofst), .out_last(olst)
  );
  sha_pad_stream #(.NW(64), .NI(16)) d64 (
    .clk(clk), .rst(rst), .in_valid(iv6), .in_ready(ir6), .in_data(id6), .in_last(il6),
    .in_bytes(ib6), .out_valid(ov6), .out_ready(ordy), .out_data(od6), .out_index(oi6),
    .out_first(of6), .out_last(ol6)
  );
  always @(negedge clk) begin
    #2;
    if (rst && ov && ordy) begin
      checks++;
      if (q32.size() == 0) begin
        errors++;
        $display("FAIL blk32 unexpected block idx=%0d", oi);
      end else begin
        m32 = q32.pop_front();
        bad32 = {oi, ofst, olst} !== {m32.idx, m32.fst, m32.lst};
        if (bad32) $display("FAIL blk32 meta got idx=%0d first=%b last=%b exp idx=%0d first=%b last=%b",
                            oi, ofst, olst, m32.idx, m32.fst, m32.lst);
        for (int i = 0; i < 16; i++)
          if (od[i*32 +: 32] !== m32.d[i*32 +: 32]) begin
            bad32 = 1;
            $display("FAIL blk32 word%0d got %h exp %h", i, od[i*32 +: 32], m32.d[i*32 +: 32]);
          end
        if (bad32) errors++;
      end
    end
  end
  always @(negedge clk) begin
    #2;
    if (rst && ov6 && ordy) begin
      checks++;
      if (q64.size() == 0) begin
        errors++;
        $display("FAIL blk64 unexpected block idx=%0d", oi6);
      end else begin
        m64 = q64.pop_front();
        bad64 = {oi6, of6, ol6} !== {m64.idx, m64.fst, m64.lst};
        if (bad64) $display("FAIL blk64 meta got idx=%0d first=%b last=%b exp idx=%0d first=%b last=%b",
                            oi6, of6, ol6, m64.idx, m64.fst, m64.lst);
        for (int i = 0; i < 16; i++)
          if (od6[i*64 +: 64] !== m64.d[i*64 +: 64]) begin
            bad64 = 1;
            $display("FAIL blk64 word%0d got %h exp %h", i, od6[i*64 +: 64], m64.d[i*64 +: 64]);
          end
        if (bad64) errors++;
      end
    end
  end
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask
  task automatic put(input logic [31:0] d, input logic l, input logic [2:0] b);
    int n = 0;
    iv = 1; id = d; il = l; ib = b;
    while (!ir && n < 100) begin @(negedge clk); n++; end
    if (!ir) chk("put32_timeout", 0, 1);
    @(negedge clk);
    iv = 0;
  endtask
  task automatic put6(input logic [63:0] d, input logic l, input logic [3:0] b);
    int n = 0;
    iv6 = 1; id6 = d; il6 = l; ib6 = b;
    while (!ir6 && n < 100) begin @(negedge clk); n++; end
    if (!ir6) chk("put64_timeout", 0, 1);
    @(negedge clk);
    iv6 = 0;
  endtask
  task automatic wait_valid(output int n);
    n = 0;
    while (!ov && n < 100) begin @(negedge clk); n++; end
  endtask
  task automatic drain();
    int n = 0;
    while ((q32.size() != 0 || q64.size() != 0) && n < 300) begin @(negedge clk); n++; end
    chk("drain_pending", 64'(q32.size() + q64.size()), 0);
    q32.delete();
    q64.delete();
    repeat (2) @(negedge clk);
  endtask
  task automatic abc_msg();
    logic [511:0] e = '0;
    int n;
    e[31:0] = 32'h61626380;
    e[15*32 +: 32] = 32'h18;
    q32.push_back('{e, 16'd0, 1'b1, 1'b1});
    put(32'h61626300, 1, 3'd3);
    wait_valid(n);
    chk("abc_latency", 64'(n), 14);
    drain();
  endtask
  initial begin
    logic [511:0] e;
    logic [1023:0] f;
    logic [511:0] sd;
    logic [15:0] si;
    int n;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", ir, 1);
    chk("rst_out_valid", ov, 0);
    chk("rst_out_data_zero", od == '0, 1);
    chk("rst_out_index", oi, 0);
    chk("rst_out_first", ofst, 1);
    chk("rst_out_last", olst, 0);
    rst = 1;
    @(negedge clk);
    abc_msg();
    e = '0;
    for (int i = 0; i < 14; i++) e[i*32 +: 32] = 32'h11111111 * 32'(i + 1);
    e[14*32 +: 32] = 32'h80000000;
    q32.push_back('{e, 16'd0, 1'b1, 1'b0});
    e = '0;
    e[15*32 +: 32] = 32'h1C0;
    q32.push_back('{e, 16'd1, 1'b0, 1'b1});
    for (int i = 0; i < 14; i++) put(32'h11111111 * 32'(i + 1), i == 13, 3'd4);
    drain();
    e = '0;
    e[31:0] = 32'h80000000;
    q32.push_back('{e, 16'd0, 1'b1, 1'b1});
    put(32'hDEADBEEF, 1, 3'd0);
    wait_valid(n);
    chk("empty_latency", 64'(n), 14);
    drain();
    e = '0;
    for (int i = 0; i < 13; i++) e[i*32 +: 32] = 32'hA0000000 + 32'(i);
    e[13*32 +: 32] = 32'hCAFE8000;
    e[15*32 +: 32] = 32'h1B0;
    q32.push_back('{e, 16'd0, 1'b1, 1'b1});
    for (int i = 0; i < 13; i++) put(32'hA0000000 + 32'(i), 0, 3'd0);
    put(32'hCAFEBABE, 1, 3'd2);
    wait_valid(n);
    chk("p13_latency", 64'(n), 1);
    drain();
    ordy = 0;
    e = '0;
    e[31:0] = 32'h61626364;
    e[63:32] = 32'h80000000;
    e[15*32 +: 32] = 32'h20;
    q32.push_back('{e, 16'd0, 1'b1, 1'b1});
    put(32'h61626364, 1, 3'd7);
    wait_valid(n);
    chk("clamp_latency", 64'(n), 14);
    sd = od;
    si = oi;
    iv = 1; id = 32'h12345678; il = 0;
    repeat (20) begin
      @(negedge clk);
      chk("stall_valid", ov, 1);
      chk("stall_ready", ir, 0);
      chk("stall_data", od == sd, 1);
      chk("stall_index", oi, 64'(si));
    end
    iv = 0;
    ordy = 1;
    drain();
    f = '0;
    for (int i = 0; i < 16; i++) f[i*64 +: 64] = 64'h0123456789ABCDEF ^ 64'(i);
    q64.push_back('{f, 16'd0, 1'b1, 1'b0});
    f = '0;
    f[63:0] = 64'h8000000000000000;
    f[15*64 +: 64] = 64'h400;
    q64.push_back('{f, 16'd1, 1'b0, 1'b1});
    for (int i = 0; i < 16; i++) put6(64'h0123456789ABCDEF ^ 64'(i), i == 15, 4'd8);
    drain();
    put(32'h61626300, 1, 3'd3);
    repeat (3) @(negedge clk);
    chk("pad_in_ready", ir, 0);
    #1 rst = 0;
    #1;
    chk("arst_in_ready", ir, 1);
    chk("arst_out_valid", ov, 0);
    chk("arst_out_index", oi, 0);
    chk("arst_out_data_zero", od == '0, 1);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    abc_msg();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    checks++;
    errors++;
    $display("FAIL watchdog expired");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
